// File: rtl/key_match_pkg.sv
// Shared constants for the key-extract / key-match stage chain.
// The key layout is 2x48 + 2x32 + 2x16 containers plus 5 comparator bits.
package key_match_pkg;

  localparam int unsigned CONT48_W  = 48;
  localparam int unsigned CONT32_W  = 32;
  localparam int unsigned CONT16_W  = 16;
  localparam int unsigned CMP_W     = 5;
  localparam int unsigned KEY_LEN   = 2*CONT48_W + 2*CONT32_W + 2*CONT16_W + CMP_W;
  localparam int unsigned PHV_LEN   = 1124;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned CNT_W     = 32;

  // Saturating increment; holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/key_match_prio_enc.sv
// Lowest-index-wins priority encoder over a hit vector; purely combinational.
// Reused by later action-lookup stages.
module key_match_prio_enc #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  hit_vec_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] addr_o
);

  always_comb begin
    hit_o  = |hit_vec_i;
    addr_o = '0;
    // Scan downwards so the last assignment is the lowest set index.
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (hit_vec_i[ADDR_W'(i - 1)]) addr_o = ADDR_W'(i - 1);
    end
  end

endmodule

// File: rtl/key_match.sv
// Two-stage ternary lookup of the extracted key against a flop-based table,
// with PHV alignment and saturating hit/miss statistics.
module key_match import key_match_pkg::*; #(
  parameter int unsigned PHV_LEN = key_match_pkg::PHV_LEN,
  parameter int unsigned KEY_LEN = key_match_pkg::KEY_LEN,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic               phv_valid_in,
  input  logic [KEY_LEN-1:0] key_in,
  input  logic               key_valid_in,
  input  logic               entry_wr_en,
  input  logic [ADDR_W-1:0]  entry_wr_addr,
  input  logic [KEY_LEN-1:0] entry_key,
  input  logic [KEY_LEN-1:0] entry_mask,
  input  logic               entry_vld,
  input  logic               cnt_clr,
  output logic [PHV_LEN-1:0] phv_out,
  output logic               phv_valid_out,
  output logic               match_valid_out,
  output logic               match_hit,
  output logic [ADDR_W-1:0]  match_addr,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  logic [KEY_LEN-1:0] tkey_q  [DEPTH];
  logic [KEY_LEN-1:0] tmask_q [DEPTH];
  logic [DEPTH-1:0]   tvld_q;

  logic [DEPTH-1:0]   hit_vec_d, s1_hit_q;
  logic [PHV_LEN-1:0] s1_phv_q, s2_phv_q;
  logic               s1_vld_q, s2_vld_q;
  logic               s2_hit_q, enc_hit;
  logic [ADDR_W-1:0]  s2_addr_q, enc_addr;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tkey_q[ADDR_W'(i)]  <= '0;
        tmask_q[ADDR_W'(i)] <= '0;
      end
      tvld_q <= '0;
    end else if (entry_wr_en) begin
      tkey_q[entry_wr_addr]  <= entry_key;
      tmask_q[entry_wr_addr] <= entry_mask;
      tvld_q[entry_wr_addr]  <= entry_vld;
    end
  end

  // Reads the table as registered, so a same-cycle write is not yet visible.
  always_comb begin
    hit_vec_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit_vec_d[ADDR_W'(i)] = tvld_q[ADDR_W'(i)] &&
        (((key_in ^ tkey_q[ADDR_W'(i)]) & tmask_q[ADDR_W'(i)]) == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_phv_q <= '0;
      s1_hit_q <= '0;
    end else begin
      s1_vld_q <= phv_valid_in;
      if (phv_valid_in) begin
        s1_phv_q <= phv_in;
        s1_hit_q <= hit_vec_d;
      end
    end
  end

  key_match_prio_enc #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_prio_enc (
    .hit_vec_i (s1_hit_q),
    .hit_o     (enc_hit),
    .addr_o    (enc_addr)
  );

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (cnt_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (s1_vld_q) begin
      hit_cnt_d  = sat_inc(hit_cnt_q, enc_hit);
      miss_cnt_d = sat_inc(miss_cnt_q, !enc_hit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q   <= 1'b0;
      s2_phv_q   <= '0;
      s2_hit_q   <= 1'b0;
      s2_addr_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      s2_vld_q   <= s1_vld_q;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (s1_vld_q) begin
        s2_phv_q  <= s1_phv_q;
        s2_hit_q  <= enc_hit;
        s2_addr_q <= enc_addr;
      end
    end
  end

  assign phv_out         = s2_phv_q;
  assign phv_valid_out   = s2_vld_q;
  assign match_valid_out = s2_vld_q;
  assign match_hit       = s2_hit_q;
  assign match_addr      = s2_addr_q;
  assign hit_cnt         = hit_cnt_q;
  assign miss_cnt        = miss_cnt_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) assert (key_valid_in == phv_valid_in);
  end
`endif

endmodule

// File: tb/tb_key_match.sv
// Randomised bench for key_match against a lookup/queue reference model.
module tb_key_match;
  import key_match_pkg::*;

  localparam int unsigned DEPTH = DEPTH_DEF;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic               clk = 1'b0;
  logic               rst;
  logic [PHV_LEN-1:0] phv_in;
  logic               phv_valid_in, key_valid_in;
  logic [KEY_LEN-1:0] key_in, entry_key, entry_mask;
  logic               entry_wr_en, entry_vld, cnt_clr;
  logic [AW-1:0]      entry_wr_addr;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_valid_out, match_valid_out, match_hit;
  logic [AW-1:0]      match_addr;
  logic [CNT_W-1:0]   hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  key_match #(.PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .phv_in(phv_in), .phv_valid_in(phv_valid_in),
    .key_in(key_in), .key_valid_in(key_valid_in),
    .entry_wr_en(entry_wr_en), .entry_wr_addr(entry_wr_addr),
    .entry_key(entry_key), .entry_mask(entry_mask), .entry_vld(entry_vld),
    .cnt_clr(cnt_clr),
    .phv_out(phv_out), .phv_valid_out(phv_valid_out),
    .match_valid_out(match_valid_out), .match_hit(match_hit),
    .match_addr(match_addr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference model: table as plain arrays, results as a timed queue.
  typedef struct {
    int                 due;
    logic [PHV_LEN-1:0] phv;
    bit                 hit;
    int                 addr;
  } res_t;

  logic [KEY_LEN-1:0] m_key  [DEPTH];
  logic [KEY_LEN-1:0] m_mask [DEPTH];
  bit                 m_vld  [DEPTH];
  res_t               rq[$];
  int                 cyc = 0;
  bit                 e_valid, e_hit;
  int                 e_addr;
  logic [PHV_LEN-1:0] e_phv;
  logic [CNT_W-1:0]   e_h, e_m;

  function automatic int lookup(input logic [KEY_LEN-1:0] k);
    for (int i = 0; i < int'(DEPTH); i++)
      if (m_vld[i] && (((k ^ m_key[i]) & m_mask[i]) == '0)) return i;
    return -1;
  endfunction

  function automatic logic [KEY_LEN-1:0] rand_key();
    logic [KEY_LEN-1:0] v = '0;
    for (int i = 0; i < 7; i++) v = {v[KEY_LEN-33:0], 32'($urandom)};
    return v;
  endfunction

  function automatic logic [PHV_LEN-1:0] rand_phv();
    logic [PHV_LEN-1:0] v = '0;
    for (int i = 0; i < 36; i++) v = {v[PHV_LEN-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic idle();
    phv_valid_in = 1'b0; key_valid_in = 1'b0;
    entry_wr_en  = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic lookup_in(input logic [KEY_LEN-1:0] k);
    phv_valid_in = 1'b1; key_valid_in = 1'b1;
    key_in = k; phv_in = rand_phv();
  endtask

  task automatic wr(input int a, input logic [KEY_LEN-1:0] k,
                    input logic [KEY_LEN-1:0] m, input bit v);
    entry_wr_en = 1'b1; entry_wr_addr = AW'(a);
    entry_key = k; entry_mask = m; entry_vld = v;
  endtask

  task automatic check_outputs();
    logic [1279:0] pa, pe;
    pa = 1280'(phv_out);
    pe = 1280'(e_phv);
    chk("phv_valid_out", 256'(phv_valid_out), 256'(e_valid));
    chk("match_valid_out", 256'(match_valid_out), 256'(e_valid));
    chk("match_hit", 256'(match_hit), 256'(e_hit));
    chk("match_addr", 256'(match_addr), 256'(e_addr));
    chk("hit_cnt", 256'(hit_cnt), 256'(e_h));
    chk("miss_cnt", 256'(miss_cnt), 256'(e_m));
    for (int c = 0; c < 5; c++)
      chk($sformatf("phv_out[%0d]", c), pa[c*256 +: 256], pe[c*256 +: 256]);
  endtask

  // One clock edge: advance the model from the inputs seen at the edge, then check.
  task automatic cycle();
    res_t r;
    int   idx;
    @(posedge clk);
    if (rst) begin
      rq.delete();
      for (int i = 0; i < int'(DEPTH); i++) begin
        m_key[i] = '0; m_mask[i] = '0; m_vld[i] = 1'b0;
      end
      e_valid = 1'b0; e_hit = 1'b0; e_addr = 0; e_phv = '0;
      e_h = '0; e_m = '0;
    end else begin
      e_valid = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        e_valid = 1'b1; e_phv = r.phv; e_hit = r.hit; e_addr = r.addr;
        if (r.hit  && e_h != 32'hFFFF_FFFF) e_h = e_h + 1;
        if (!r.hit && e_m != 32'hFFFF_FFFF) e_m = e_m + 1;
      end
      if (cnt_clr) begin e_h = '0; e_m = '0; end
      if (phv_valid_in) begin
        idx    = lookup(key_in);
        r.due  = cyc + 1;
        r.phv  = phv_in;
        r.hit  = (idx >= 0);
        r.addr = (idx >= 0) ? idx : 0;
        rq.push_back(r);
      end
      if (entry_wr_en) begin
        m_key[entry_wr_addr]  = entry_key;
        m_mask[entry_wr_addr] = entry_mask;
        m_vld[entry_wr_addr]  = entry_vld;
      end
    end
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  logic [KEY_LEN-1:0] kk;

  initial begin
    rst = 1'b1; idle();
    phv_in = '0; key_in = '0; entry_key = '0; entry_mask = '0;
    entry_vld = 1'b0; entry_wr_addr = '0;
    repeat (2) cycle();
    rst = 1'b0;

    // Empty table: first lookup misses.
    lookup_in(rand_key()); cycle();
    idle(); repeat (2) cycle();
    chk("first_miss_cnt", 256'(miss_cnt), 256'(1));

    // Exact entry 3, default entry 7.
    kk = rand_key();
    wr(3, kk, '1, 1'b1); cycle();
    wr(7, rand_key(), '0, 1'b1); cycle();
    idle(); lookup_in(kk); cycle();
    lookup_in(kk ^ KEY_LEN'(1)); cycle();
    idle(); repeat (2) cycle();
    chk("two_hits", 256'(hit_cnt), 256'(2));

    // Same-cycle write sees old contents; the next lookup sees the new entry.
    wr(3, kk, '1, 1'b0); cycle();
    idle(); wr(3, kk, '1, 1'b1); lookup_in(kk); cycle();
    idle(); lookup_in(kk); cycle();
    idle(); repeat (2) cycle();

    // Back-to-back stream.
    for (int i = 0; i < 20; i++) begin
      lookup_in(rand_key() & {KEY_LEN{i[0]}}); cycle();
    end
    idle(); repeat (2) cycle();

    // Saturation near the top of the hit counter.
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt_q;
    e_h = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin lookup_in(kk); cycle(); end
    idle(); repeat (2) cycle();
    chk("hit_sat", 256'(hit_cnt), 256'(32'hFFFF_FFFF));
    lookup_in(kk); cycle();
    idle(); cnt_clr = 1'b1; cycle();
    cnt_clr = 1'b0; cycle();
    chk("clr_wins", 256'(hit_cnt), 256'(0));

    // Randomised traffic and table churn.
    for (int n = 0; n < 300; n++) begin
      idle();
      if ($urandom % 4 != 0) begin
        int j = int'($urandom % DEPTH);
        lookup_in(m_key[j] ^ (($urandom % 3 == 0) ? (rand_key() & rand_key() & rand_key()) : '0));
      end
      if ($urandom % 4 == 0) begin
        case ($urandom % 4)
          0: wr(int'($urandom % DEPTH), rand_key(), '1, ($urandom % 5) != 0);
          1: wr(int'($urandom % DEPTH), rand_key(), '0, ($urandom % 5) != 0);
          2: wr(int'($urandom % DEPTH), rand_key(), rand_key(), ($urandom % 5) != 0);
          default: wr(int'($urandom % DEPTH), rand_key(), rand_key() & rand_key() & rand_key(),
                      ($urandom % 5) != 0);
        endcase
      end
      cnt_clr = ($urandom % 40) == 0;
      cycle();
    end
    idle(); repeat (2) cycle();

    // Reset with lookups in flight.
    lookup_in(kk); cycle();
    lookup_in(kk); rst = 1'b1; cycle();
    idle(); rst = 1'b0;
    chk("rst_valid", 256'(phv_valid_out), 256'(0));
    chk("rst_hit_cnt", 256'(hit_cnt), 256'(0));
    chk("rst_miss_cnt", 256'(miss_cnt), 256'(0));
    repeat (2) cycle();
    lookup_in(kk); cycle();
    idle(); cycle();
    chk("post_rst_miss", 256'(match_hit), 256'(0));
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
